// File: rtl/frame_serializer.sv
// Captures a parallel time frame and emits it MSB-first as QPSK dibits, one symbol per SYM_DIV clocks.
// Optional additive x^7+x^4+1 scrambler enabled by defining FRAME_SCRAMBLE_EN.
module frame_serializer #(
  parameter int FRAME_W = 40,
  parameter int SYM_DIV = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [FRAME_W-1:0] para_i,
  input  logic               load_i,
  output logic               busy_o,
  output logic               i_o,
  output logic               q_o,
  output logic               sym_valid_o,
  output logic               frame_done_o,
  output logic               overrun_o
);

  localparam int NSYM  = FRAME_W / 2;
  localparam int DIV_W = $clog2(SYM_DIV);
  localparam int SYM_W = $clog2(NSYM) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NSYM - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic               busy_q, busy_d;
  logic               i_q, i_d;
  logic               q_q, q_d;
  logic               sym_valid_q, sym_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;
  logic               tx_i, tx_q;

`ifdef FRAME_SCRAMBLE_EN
  logic [6:0] scr_q, scr_d;
  logic       scr_r1, scr_r2;

  // Two scrambler steps per symbol: the I bit consumes the first output, Q the second.
  assign scr_r1 = scr_q[6] ^ scr_q[3];
  assign scr_r2 = scr_q[5] ^ scr_q[2];
  assign tx_i   = shreg_q[FRAME_W-1] ^ scr_r1;
  assign tx_q   = shreg_q[FRAME_W-2] ^ scr_r2;
`else
  assign tx_i = shreg_q[FRAME_W-1];
  assign tx_q = shreg_q[FRAME_W-2];
`endif

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    div_cnt_d    = div_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    i_d          = i_q;
    q_d          = q_q;
    sym_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    // Stays high through the cycle of the last symbol, drops one cycle later.
    busy_d       = (state_q == SHIFT);
`ifdef FRAME_SCRAMBLE_EN
    scr_d        = scr_q;
`endif

    case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d   = SHIFT;
          shreg_d   = para_i;
          div_cnt_d = '0;
          sym_cnt_d = '0;
          busy_d    = 1'b1;
`ifdef FRAME_SCRAMBLE_EN
          scr_d     = 7'h7F;
`endif
        end
      end
      SHIFT: begin
        overrun_d = load_i;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d   = '0;
          i_d         = tx_i;
          q_d         = tx_q;
          sym_valid_d = 1'b1;
          shreg_d     = {shreg_q[FRAME_W-3:0], 2'b00};
          sym_cnt_d   = sym_cnt_q + SYM_W'(1);
`ifdef FRAME_SCRAMBLE_EN
          scr_d       = {scr_q[4:0], scr_r1, scr_r2};
`endif
          if (sym_cnt_q == SYM_LAST) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      div_cnt_q    <= '0;
      sym_cnt_q    <= '0;
      busy_q       <= 1'b0;
      i_q          <= 1'b0;
      q_q          <= 1'b0;
      sym_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef FRAME_SCRAMBLE_EN
      scr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      div_cnt_q    <= div_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      busy_q       <= busy_d;
      i_q          <= i_d;
      q_q          <= q_d;
      sym_valid_q  <= sym_valid_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
`ifdef FRAME_SCRAMBLE_EN
      scr_q        <= scr_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign i_o          = i_q;
  assign q_o          = q_q;
  assign sym_valid_o  = sym_valid_q;
  assign frame_done_o = frame_done_q;
  assign overrun_o    = overrun_q;

endmodule
